// File: rtl/toy_fetch_req_agent.sv
// toy_fetch_req_agent: initiator side of the fetch_mem req/ack interface.
// Upstream addresses are tagged with {epoch, slot}, issued in order, acked in
// any order, and handed downstream strictly in issue order. A flush retires
// the current epoch so late acks from before the flush are recognised and dropped.
module toy_fetch_req_agent #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 16,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      up_vld,
  output logic                      up_rdy,
  input  logic [ADDR_WIDTH-1:0]     up_addr,
  output logic                      fetch_mem_req_vld,
  input  logic                      fetch_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]     fetch_mem_req_addr,
  output logic [ID_WIDTH-1:0]       fetch_mem_req_entry_id,
  input  logic                      fetch_mem_ack_vld,
  output logic                      fetch_mem_ack_rdy,
  input  logic [DATA_WIDTH-1:0]     fetch_mem_ack_data,
  input  logic [ID_WIDTH-1:0]       fetch_mem_ack_entry_id,
  output logic                      down_vld,
  input  logic                      down_rdy,
  output logic [ADDR_WIDTH-1:0]     down_addr,
  output logic [DATA_WIDTH-1:0]     down_data,
  output logic [$clog2(DEPTH):0]    outstanding_cnt,
  output logic [15:0]               stale_drop_cnt,
  output logic                      proto_err
);

  localparam int SLOT_W = $clog2(DEPTH);
  localparam logic [SLOT_W:0] FULL_CNT = (SLOT_W + 1)'(DEPTH);

  logic                  epoch_reg;
  logic [SLOT_W-1:0]     wr_ptr_reg;
  logic [SLOT_W-1:0]     rd_ptr_reg;
  logic [SLOT_W:0]       count_reg;
  logic [15:0]           stale_cnt_reg;
  logic                  proto_err_reg;

  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      done;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic                  full;
  logic                  issue;
  logic                  deliver;
  logic                  ack_fire;
  logic [SLOT_W-1:0]     ack_slot;
  logic                  ack_epoch;
  logic                  ack_upper_zero;
  logic                  ack_hit;
  logic                  ack_accept;
  logic                  ack_dup;
  logic                  ack_stale;

  // Issue, ack classification and delivery handshakes are all combinational.
  always_comb begin
    full               = (count_reg == FULL_CNT);
    fetch_mem_req_vld  = ~rst & up_vld & ~full & ~flush;
    up_rdy             = ~rst & fetch_mem_req_rdy & ~full & ~flush;
    fetch_mem_req_addr = up_addr;
    fetch_mem_req_entry_id = {{(ID_WIDTH - SLOT_W - 1){1'b0}}, epoch_reg, wr_ptr_reg};
    issue              = fetch_mem_req_vld & fetch_mem_req_rdy;

    // Slots are pre-allocated at issue time, so acks are never backpressured.
    fetch_mem_ack_rdy  = ~rst;
    ack_fire           = fetch_mem_ack_vld & ~rst;
    ack_slot           = fetch_mem_ack_entry_id[SLOT_W-1:0];
    ack_epoch          = fetch_mem_ack_entry_id[SLOT_W];
    // Issued ids are zero above the epoch bit; anything else cannot be ours.
    ack_upper_zero     = (fetch_mem_ack_entry_id[ID_WIDTH-1:SLOT_W+1] == '0);
    ack_hit            = ack_fire & ~flush & ack_upper_zero &
                         (ack_epoch == epoch_reg) & pend[ack_slot];
    ack_accept         = ack_hit & ~done[ack_slot];
    ack_dup            = ack_hit & done[ack_slot];
    ack_stale          = ack_fire & ~ack_hit;

    down_vld           = ~rst & ~flush & done[rd_ptr_reg];
    down_addr          = addr_mem[rd_ptr_reg];
    down_data          = data_mem[rd_ptr_reg];
    deliver            = down_vld & down_rdy;

    outstanding_cnt    = count_reg;
    stale_drop_cnt     = stale_cnt_reg;
    proto_err          = proto_err_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic                  pend_reg;
      logic                  done_reg;
      logic [ADDR_WIDTH-1:0] addr_reg;
      logic [DATA_WIDTH-1:0] data_reg;

      // Per-slot lifecycle: allocate on issue, fill on ack, release on delivery.
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg <= 1'b0;
          done_reg <= 1'b0;
          addr_reg <= '0;
          data_reg <= '0;
        end else if (flush) begin
          pend_reg <= 1'b0;
          done_reg <= 1'b0;
        end else begin
          if (issue && wr_ptr_reg == SLOT_W'(gi)) begin
            pend_reg <= 1'b1;
            addr_reg <= up_addr;
          end
          if (ack_accept && ack_slot == SLOT_W'(gi)) begin
            done_reg <= 1'b1;
            data_reg <= fetch_mem_ack_data;
          end
          if (deliver && rd_ptr_reg == SLOT_W'(gi)) begin
            pend_reg <= 1'b0;
            done_reg <= 1'b0;
          end
        end
      end

      assign pend[gi]     = pend_reg;
      assign done[gi]     = done_reg;
      assign addr_mem[gi] = addr_reg;
      assign data_mem[gi] = data_reg;
    end
  endgenerate

  // Ring pointers, occupancy and epoch; flush starts a fresh epoch at slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      epoch_reg  <= ~epoch_reg;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (issue)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deliver) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({issue, deliver})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Diagnostics: saturating stale-ack counter and sticky duplicate-ack flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stale_cnt_reg <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (ack_stale && stale_cnt_reg != 16'hFFFF) stale_cnt_reg <= stale_cnt_reg + 16'd1;
      if (ack_dup) proto_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toy_fetch_req_agent.sv
// Self-checking bench for toy_fetch_req_agent: directed scenarios then random
// traffic, all compared against an in-order queue model of in-flight fetches.
module tb_toy_fetch_req_agent;

  localparam int AW    = 32;
  localparam int DW    = 256;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst, flush, up_vld, up_rdy;
  logic [AW-1:0] up_addr;
  logic          req_vld, req_rdy;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] req_id;
  logic          ack_vld, ack_rdy;
  logic [DW-1:0] ack_data;
  logic [IW-1:0] ack_id;
  logic          down_vld, down_rdy;
  logic [AW-1:0] down_addr;
  logic [DW-1:0] down_data;
  logic [SW:0]   outstanding_cnt;
  logic [15:0]   stale_drop_cnt;
  logic          proto_err;

  always #5 clk = ~clk;

  toy_fetch_req_agent #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_vld(up_vld), .up_rdy(up_rdy), .up_addr(up_addr),
    .fetch_mem_req_vld(req_vld), .fetch_mem_req_rdy(req_rdy),
    .fetch_mem_req_addr(req_addr), .fetch_mem_req_entry_id(req_id),
    .fetch_mem_ack_vld(ack_vld), .fetch_mem_ack_rdy(ack_rdy),
    .fetch_mem_ack_data(ack_data), .fetch_mem_ack_entry_id(ack_id),
    .down_vld(down_vld), .down_rdy(down_rdy), .down_addr(down_addr), .down_data(down_data),
    .outstanding_cnt(outstanding_cnt), .stale_drop_cnt(stale_drop_cnt), .proto_err(proto_err)
  );

  // Reference model: fetches in issue order, each remembering its slot and ack data.
  typedef struct {
    logic [AW-1:0] addr;
    int            slot;
    logic [DW-1:0] data;
    bit            got;
  } ent_t;

  ent_t q[$];
  int   m_epoch;
  int   m_issued;
  int   m_stale;
  bit   m_proto;
  int   checks;
  int   failures;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle();
    rst = 0; flush = 0; up_vld = 0; up_addr = '0; req_rdy = 0;
    ack_vld = 0; ack_id = '0; ack_data = '0; down_rdy = 0;
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic step();
    bit            full, e_req_vld, e_up_rdy, e_down_vld;
    logic [IW-1:0] e_id;
    int            s, e, idx;
    #1;
    full       = (q.size() == DEPTH);
    e_req_vld  = !rst && up_vld && !full && !flush;
    e_up_rdy   = !rst && req_rdy && !full && !flush;
    e_down_vld = !rst && !flush && q.size() > 0 && q[0].got;
    e_id       = IW'(m_epoch * DEPTH + (m_issued % DEPTH));

    check_val("req_vld", req_vld, e_req_vld);
    check_val("up_rdy", up_rdy, e_up_rdy);
    check_val("ack_rdy", ack_rdy, !rst);
    check_val("down_vld", down_vld, e_down_vld);
    check_val("outstanding", outstanding_cnt, q.size());
    check_val("stale_cnt", stale_drop_cnt, m_stale);
    check_val("proto_err", proto_err, m_proto);
    if (e_req_vld) begin
      check_val("req_addr", req_addr, up_addr);
      check_val("entry_id", req_id, e_id);
    end
    if (e_down_vld) begin
      check_val("down_addr", down_addr, q[0].addr);
      check_val("down_data", down_data, q[0].data);
      if (down_rdy) $display("deliver addr=%08h data=%08h", q[0].addr, q[0].data[31:0]);
    end

    if (rst) begin
      q.delete(); m_epoch = 0; m_issued = 0; m_stale = 0; m_proto = 0;
    end else if (flush) begin
      if (ack_vld && m_stale < 65535) m_stale++;
      q.delete(); m_epoch = 1 - m_epoch; m_issued = 0;
    end else begin
      if (ack_vld) begin
        s = int'(ack_id) % DEPTH;
        e = (int'(ack_id) / DEPTH) % 2;
        idx = -1;
        if (int'(ack_id) < 2 * DEPTH && e == m_epoch)
          foreach (q[i]) if (q[i].slot == s) idx = i;
        if (idx < 0) begin
          if (m_stale < 65535) m_stale++;
        end else if (q[idx].got) begin
          m_proto = 1;
        end else begin
          q[idx].data = ack_data;
          q[idx].got  = 1;
        end
      end
      if (e_down_vld && down_rdy) void'(q.pop_front());
      if (e_req_vld && req_rdy) begin
        q.push_back('{addr: up_addr, slot: m_issued % DEPTH, data: '0, got: 0});
        m_issued++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic issue_one(input logic [AW-1:0] a);
    idle(); up_vld = 1; up_addr = a; req_rdy = 1; step();
  endtask

  task automatic ack_one(input int id);
    idle(); ack_vld = 1; ack_id = IW'(id); ack_data = rand_line(); step();
  endtask

  int ooo_ids[4] = '{3, 1, 0, 2};

  initial begin
    checks = 0; failures = 0;
    m_epoch = 0; m_issued = 0; m_stale = 0; m_proto = 0;
    idle(); rst = 1;
    @(posedge clk); #1;

    // Handshakes stay low while reset is held even with active inputs.
    up_vld = 1; req_rdy = 1; ack_vld = 1; down_rdy = 1; up_addr = 32'h40;
    step();

    // Single fetch: ack three cycles after issue, delivery follows.
    idle();
    issue_one(32'h100);
    idle(); req_rdy = 1; step(); step();
    ack_one(0);
    idle(); down_rdy = 1; step(); step();

    // Out-of-order acks, full backpressure, duplicate ack.
    do_reset();
    for (int k = 0; k < 4; k++) issue_one(AW'(k * 32'h20));
    issue_one(32'h80);
    foreach (ooo_ids[k]) ack_one(ooo_ids[k]);
    ack_one(1);
    idle(); down_rdy = 1; up_vld = 1; req_rdy = 1; up_addr = 32'h80; step();
    step();
    idle(); down_rdy = 1;
    for (int k = 0; k < 4; k++) step();

    // Flush with three in flight; old-epoch acks get dropped.
    do_reset();
    for (int k = 0; k < 3; k++) issue_one(AW'(32'h200 + k * 32'h20));
    idle(); flush = 1; step();
    for (int k = 0; k < 3; k++) begin
      idle(); down_rdy = 1; ack_vld = 1; ack_id = IW'(k); ack_data = rand_line(); step();
    end
    check_val("flush_stale3", stale_drop_cnt, 3);
    issue_one(32'h300);

    // Reset with two completed lines waiting.
    do_reset();
    issue_one(32'h400); issue_one(32'h420);
    ack_one(0); ack_one(1);
    idle(); step();
    idle(); rst = 1; step();
    idle(); down_rdy = 1; step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst      = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      up_vld   = ($urandom_range(0, 3) != 0);
      up_addr  = $urandom & 32'hFFFF_FFE0;
      req_rdy  = ($urandom_range(0, 3) != 0);
      down_rdy = ($urandom_range(0, 4) < 3);
      if ($urandom_range(0, 1) == 1) begin
        ack_vld  = 1;
        ack_data = rand_line();
        if (q.size() > 0 && $urandom_range(0, 9) < 8)
          ack_id = IW'(m_epoch * DEPTH + q[$urandom_range(0, q.size() - 1)].slot);
        else if ($urandom_range(0, 9) == 0)
          ack_id = IW'($urandom_range(0, 65535));
        else
          ack_id = IW'($urandom_range(0, 2 * DEPTH - 1));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
